// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit holding HI/LO for the E stage.
// Optional madd/maddu (codes 11/12) are built only when MDU_MADD_EN is defined.
module md_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       md_sel,
    input  logic             req_valid,
    input  logic             flush,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             start,
    output logic             busy,
    output logic             md_stall,
    output logic [WIDTH-1:0] md_out,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;
    localparam logic [3:0] OP_MADD  = 4'd11;
    localparam logic [3:0] OP_MADDU = 4'd12;

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic             is_arith, accept, last, done, is_div, b_zero, wr_res;
    logic [CW-1:0]    lat;
    logic [2*WIDTH-1:0] prod_s, prod_u, acc, res;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag, q_mag, r_mag, ub_safe;

    always_comb begin
        is_arith = 1'b0;
        case (md_sel)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MSUB, OP_MSUBU: is_arith = 1'b1;
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU: is_arith = 1'b1;
`endif
            default: is_arith = 1'b0;
        endcase
    end

    // FSM: state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_RUN;
            S_RUN:  if (flush || cnt_q == CW'(1)) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy     = (state_q == S_RUN);
        accept   = req_valid & ~flush & ~busy;
        start    = accept & is_arith;
        md_stall = start | busy;
        last     = busy & (cnt_q == CW'(1));
        done     = last & ~flush;
    end

    always_comb begin
        md_out = '0;
        case (md_sel)
            OP_MFHI: md_out = hi_q;
            OP_MFLO: md_out = lo_q;
            default: md_out = '0;
        endcase
    end

    // Product/quotient are evaluated from the latched operands and the HI/LO at completion.
    always_comb begin
        prod_s  = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
        prod_u  = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
        acc     = {hi_q, lo_q};
        b_zero  = (b_q == '0);
        is_div  = (op_q == OP_DIV) || (op_q == OP_DIVU);
        a_neg   = (op_q == OP_DIV) & a_q[WIDTH-1];
        b_neg   = (op_q == OP_DIV) & b_q[WIDTH-1];
        a_mag   = a_neg ? -a_q : a_q;
        b_mag   = b_neg ? -b_q : b_q;
        ub_safe = b_zero ? WIDTH'(1) : b_mag;
        q_mag   = a_mag / ub_safe;
        r_mag   = a_mag % ub_safe;
        res     = acc;
        case (op_q)
            OP_MULT:  res = prod_s;
            OP_MULTU: res = prod_u;
            OP_MSUB:  res = acc - prod_s;
            OP_MSUBU: res = acc - prod_u;
`ifdef MDU_MADD_EN
            OP_MADD:  res = acc + prod_s;
            OP_MADDU: res = acc + prod_u;
`endif
            OP_DIV, OP_DIVU: res = {(a_neg ? -r_mag : r_mag),
                                    ((a_neg ^ b_neg) ? -q_mag : q_mag)};
            default:  res = acc;
        endcase
        wr_res = done & ~(is_div & b_zero);
    end

    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        op_d  = op_q;
        cnt_d = cnt_q;
        hi_d  = hi_q;
        lo_d  = lo_q;
        lat   = (md_sel == OP_DIV || md_sel == OP_DIVU) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        if (start) begin
            a_d   = a;
            b_d   = b;
            op_d  = md_sel;
            cnt_d = lat;
        end else if (busy) begin
            cnt_d = flush ? '0 : cnt_q - CW'(1);
        end
        if (wr_res) begin
            hi_d = res[2*WIDTH-1:WIDTH];
            lo_d = res[WIDTH-1:0];
        end else if (accept && md_sel == OP_MTHI) begin
            hi_d = a;
        end else if (accept && md_sel == OP_MTLO) begin
            lo_d = a;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            cnt_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            op_q  <= op_d;
            cnt_q <= cnt_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;
endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: a driver pushes expected HI/LO and busy length per op,
// a negedge monitor pops and compares when busy falls.
module tb_md_unit;
    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0, reset_n = 1'b0;
    logic [3:0]  md_sel = 4'd0;
    logic        req_valid = 1'b0, flush = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic        start, busy, md_stall;
    logic [31:0] md_out, hi, lo;

    md_unit dut (
        .clk(clk), .reset_n(reset_n), .md_sel(md_sel), .req_valid(req_valid),
        .flush(flush), .a(a), .b(b), .start(start), .busy(busy),
        .md_stall(md_stall), .md_out(md_out), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
        string       name;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0, passes = 0;
    logic [31:0] hi_m = '0, lo_m = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else passes++;
    endtask

    function automatic bit arith_m(input logic [3:0] s);
        bit r;
        r = s inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd9, 4'd10};
`ifdef MDU_MADD_EN
        r = r | (s inside {4'd11, 4'd12});
`endif
        return r;
    endfunction

    // Reference model: plain 64-bit arithmetic and SV's own signed divide.
    task automatic model_arith(input logic [3:0] sel, input logic [31:0] av, input logic [31:0] bv,
                               output exp_t e);
        logic [63:0] acc, ps, pu, r;
        int q, rm;
        acc = {hi_m, lo_m};
        ps  = 64'(longint'($signed(av)) * longint'($signed(bv)));
        pu  = {32'b0, av} * {32'b0, bv};
        r   = acc;
        case (sel)
            4'd1:  r = ps;
            4'd2:  r = pu;
            4'd9:  r = acc - ps;
            4'd10: r = acc - pu;
            4'd11: r = acc + ps;
            4'd12: r = acc + pu;
            4'd3: if (bv != 0) begin
                if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) r = {32'h0, 32'h8000_0000};
                else begin
                    q  = $signed(av) / $signed(bv);
                    rm = $signed(av) % $signed(bv);
                    r  = {32'(rm), 32'(q)};
                end
            end
            4'd4: if (bv != 0) r = {av % bv, av / bv};
            default: r = acc;
        endcase
        e.hi   = r[63:32];
        e.lo   = r[31:0];
        e.lat  = (sel == 4'd3 || sel == 4'd4) ? DC : MC;
        e.name = $sformatf("op%0d_a%h_b%h", sel, av, bv);
    endtask

    task automatic issue(input logic [3:0] sel, input logic [31:0] av, input logic [31:0] bv,
                         input logic fl, input bit exp_st, input bit bsy);
        @(posedge clk); #1;
        md_sel = sel; a = av; b = bv; req_valid = 1'b1; flush = fl;
        #1;
        chk($sformatf("start_op%0d", sel), 64'(start), 64'(exp_st));
        chk($sformatf("stall_op%0d", sel), 64'(md_stall), 64'(exp_st | bsy));
        @(posedge clk); #1;
        req_valid = 1'b0; md_sel = 4'd0; flush = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 60);
        chk("idle_wait", 64'(busy), 64'(0));
    endtask

    task automatic read_back(input string tag);
        md_sel = 4'd5; #1;
        chk({tag, "_mfhi"}, 64'(md_out), 64'(hi_m));
        md_sel = 4'd6; #1;
        chk({tag, "_mflo"}, 64'(md_out), 64'(lo_m));
        md_sel = 4'd0; #1;
        chk({tag, "_mdout0"}, 64'(md_out), 64'(0));
    endtask

    task automatic run_op(input logic [3:0] sel, input logic [31:0] av, input logic [31:0] bv);
        exp_t e;
        bit ar;
        ar = arith_m(sel);
        if (ar) model_arith(sel, av, bv, e);
        issue(sel, av, bv, 1'b0, ar, 1'b0);
        if (ar) begin
            sbq.push_back(e);
            hi_m = e.hi;
            lo_m = e.lo;
            wait_idle();
        end else begin
            if (sel == 4'd7) hi_m = av;
            if (sel == 4'd8) lo_m = av;
            chk($sformatf("nobusy_op%0d", sel), 64'(busy), 64'(0));
            read_back($sformatf("after_op%0d", sel));
        end
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h1;
            4: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: counts busy cycles, scores each completion against the queue.
    initial begin
        int  bcnt = 0;
        bit  pb = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (busy) begin
                bcnt++;
                chk("stall_while_busy", 64'(md_stall), 64'(1));
            end else if (pb) begin
                chk("sb_has_entry", 64'(sbq.size() > 0), 64'(1));
                if (sbq.size() > 0) begin
                    e = sbq.pop_front();
                    chk({e.name, "_lat"}, 64'(bcnt), 64'(e.lat));
                    chk({e.name, "_hi"}, 64'(hi), 64'(e.hi));
                    chk({e.name, "_lo"}, 64'(lo), 64'(e.lo));
                end
                bcnt = 0;
            end
            pb = busy;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        logic [3:0] sels[12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd9, 4'd10, 4'd7, 4'd8,
                                 4'd5, 4'd6, 4'd11, 4'd12};
        #3;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_hi", 64'(hi), 64'(0));
        chk("rst_lo", 64'(lo), 64'(0));
        chk("rst_start", 64'(start), 64'(0));
        chk("rst_stall", 64'(md_stall), 64'(0));
        chk("rst_mdout", 64'(md_out), 64'(0));
        #9 reset_n = 1'b1;

        run_op(4'd1, 32'hFFFF_FFFE, 32'd3);
        run_op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(4'd10, 32'd1, 32'd1);
        run_op(4'd3, 32'hFFFF_FFF9, 32'd2);
        run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);

        // Divide by zero with an mtlo attempted while busy
        run_op(4'd7, 32'h1234, 32'd0);
        run_op(4'd8, 32'h0, 32'd0);
        model_arith(4'd3, 32'd5, 32'd0, e);
        issue(4'd3, 32'd5, 32'd0, 1'b0, 1'b1, 1'b0);
        sbq.push_back(e);
        issue(4'd8, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0, 1'b1);
        wait_idle();
        read_back("divzero");

        // Flush in the third busy cycle discards the op
        run_op(4'd7, 32'h0BAD_F00D, 32'd0);
        issue(4'd1, 32'd7, 32'd9, 1'b0, 1'b1, 1'b0);
        sbq.push_back('{hi: hi_m, lo: lo_m, lat: 3, name: "flushed_mult"});
        @(posedge clk);
        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        wait_idle();

        // Flush in IDLE drops the request
        issue(4'd1, 32'd3, 32'd3, 1'b1, 1'b0, 1'b0);
        chk("flush_idle_drop", 64'(busy), 64'(0));
        read_back("flush_idle");

        // Async reset mid-divide
        issue(4'd4, 32'd100, 32'd7, 1'b0, 1'b1, 1'b0);
        sbq.push_back('{hi: 32'h0, lo: 32'h0, lat: 3, name: "reset_div"});
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'(0));
        chk("arst_hi", 64'(hi), 64'(0));
        chk("arst_lo", 64'(lo), 64'(0));
        hi_m = '0;
        lo_m = '0;
        #3 reset_n = 1'b1;
        wait_idle();

`ifdef MDU_MADD_EN
        run_op(4'd7, 32'h0, 32'd0);
        run_op(4'd8, 32'hFFFF_FFFF, 32'd0);
        run_op(4'd12, 32'd1, 32'd1);
        run_op(4'd11, 32'hFFFF_FFFF, 32'd5);
`else
        run_op(4'd7, 32'h55, 32'd0);
        run_op(4'd11, 32'd3, 32'd4);
        run_op(4'd12, 32'd3, 32'd4);
`endif

        for (int i = 0; i < 40; i++) begin
            run_op(sels[$urandom_range(0, 11)], rnd_val(), rnd_val());
        end

        repeat (2) @(posedge clk);
        chk("sb_drained", 64'(sbq.size()), 64'(0));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
